// File: rtl/formula_pkg.sv
// rtl/formula_pkg.sv - shared types and helpers for the formula result path
package formula_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int TAG_W_MAX   = 6;

  // Tag width for a given entry count; never below one bit.
  function automatic int tag_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  typedef struct packed {
    logic [TAG_W_MAX-1:0]  tag;
    logic [DATA_W_DEF-1:0] data;
  } result_t;

endpackage

// File: rtl/formula_result_reorder_if.sv
// rtl/formula_result_reorder_if.sv - allocate/complete/retire bus of the reorder buffer
interface formula_result_reorder_if import formula_pkg::*; #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = DATA_W_DEF
) ();
  localparam int TAG_W = tag_w(DEPTH);

  logic              alloc_req;
  logic              alloc_rdy;
  logic [TAG_W-1:0]  alloc_tag;
  logic              cmp_vld;
  logic [TAG_W-1:0]  cmp_tag;
  logic [DATA_W-1:0] cmp_data;
  logic              out_vld;
  logic              out_rdy;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W:0]    occupancy;
  logic              err;

  modport master (
    output alloc_req, cmp_vld, cmp_tag, cmp_data, out_rdy,
    input  alloc_rdy, alloc_tag, out_vld, out_data, occupancy, err
  );

  modport slave (
    input  alloc_req, cmp_vld, cmp_tag, cmp_data, out_rdy,
    output alloc_rdy, alloc_tag, out_vld, out_data, occupancy, err
  );

endinterface

// File: rtl/formula_result_reorder_slot_array.sv
// rtl/formula_result_reorder_slot_array.sv - result storage, one write port, one async read port
module reorder_slot_array #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 3
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [TAG_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [TAG_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  // Contents are qualified by the done bits in the top, so no reset is needed.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/formula_result_reorder.sv
// rtl/formula_result_reorder.sv - tags dispatched arguments, accepts results out of order, releases in order
module formula_result_reorder import formula_pkg::*; #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  formula_result_reorder_if.slave bus
);

  localparam int TAG_W = tag_w(DEPTH);
  localparam logic [TAG_W:0] FULL = (TAG_W+1)'(DEPTH);

  logic [TAG_W-1:0]  head;
  logic [TAG_W-1:0]  tail;
  logic [TAG_W:0]    count;
  logic [DEPTH-1:0]  alloc_bits;
  logic [DEPTH-1:0]  done_bits;
  logic              err_q;
  logic [DATA_W-1:0] head_data;

  logic do_alloc;
  logic cmp_ok;
  logic cmp_bad;
  logic do_retire;

  // All decisions use pre-edge state, so a retire never frees a slot for the same cycle.
  assign do_alloc  = bus.alloc_req & (count != FULL);
  assign cmp_ok    = bus.cmp_vld & alloc_bits[bus.cmp_tag] & ~done_bits[bus.cmp_tag];
  assign cmp_bad   = bus.cmp_vld & ~cmp_ok;
  assign do_retire = done_bits[head] & bus.out_rdy;

  reorder_slot_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W)
  ) u_slots (
    .clk     (clk),
    .wr_en   (cmp_ok),
    .wr_addr (bus.cmp_tag),
    .wr_data (bus.cmp_data),
    .rd_addr (head),
    .rd_data (head_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      alloc_bits <= '0;
      done_bits  <= '0;
      err_q      <= 1'b0;
    end else begin
      // Legal traffic never makes alloc, completion and retire touch the same index.
      if (do_alloc) begin
        alloc_bits[tail] <= 1'b1;
        done_bits[tail]  <= 1'b0;
        tail             <= tail + 1'b1;
      end
      if (cmp_ok) begin
        done_bits[bus.cmp_tag] <= 1'b1;
      end
      if (cmp_bad) begin
        err_q <= 1'b1;
      end
      if (do_retire) begin
        alloc_bits[head] <= 1'b0;
        done_bits[head]  <= 1'b0;
        head             <= head + 1'b1;
      end
      case ({do_alloc, do_retire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign bus.alloc_rdy = (count != FULL);
  assign bus.alloc_tag = tail;
  assign bus.out_vld   = done_bits[head];
  assign bus.out_data  = head_data;
  assign bus.occupancy = count;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_formula_result_reorder.sv
// tb/tb_formula_result_reorder.sv - scoreboard bench for formula_result_reorder
module tb_formula_result_reorder;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  formula_result_reorder_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

  formula_result_reorder #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Reference: outstanding tags in dispatch order, expected outputs in dispatch order.
  int          tagq[$];
  logic [31:0] expq[$];
  bit          mdone [DEPTH];
  logic [31:0] pend_data [DEPTH];
  int          next_tag = 0;
  bit          merr = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_ret = 0;
  int          ord [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_flight(input int t);
    foreach (tagq[i]) if (tagq[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit head_done();
    if (tagq.size() == 0) return 1'b0;
    return mdone[tagq[0]];
  endfunction

  function automatic int pick_incomplete();
    int cand[$];
    foreach (tagq[i]) if (!mdone[tagq[i]]) cand.push_back(tagq[i]);
    if (cand.size() == 0) return -1;
    return cand[$urandom_range(0, cand.size() - 1)];
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("occupancy", bus.occupancy, tagq.size());
      chk("alloc_rdy", bus.alloc_rdy, tagq.size() < DEPTH);
      chk("alloc_tag", bus.alloc_tag, next_tag);
      chk("err", bus.err, merr);
      chk("out_vld", bus.out_vld, head_done());
      if (bus.out_vld) begin
        if (expq.size() == 0) begin
          chk("out_unexpected", bus.out_vld, 1'b0);
        end else begin
          chk("out_data", bus.out_data, expq[0]);
          if (bus.out_rdy) begin
            void'(expq.pop_front());
            n_ret++;
          end
        end
      end
    end
  end

  task automatic cycle(input bit a, input logic [31:0] ad, input bit cv, input int ct,
                       input logic [31:0] cd, input bit ordy);
    bit acc, cok, ret;
    bus.alloc_req = a;
    bus.cmp_vld   = cv;
    bus.cmp_tag   = TAG_W'(ct);
    bus.cmp_data  = cd;
    bus.out_rdy   = ordy;
    acc = a && (tagq.size() < DEPTH);
    cok = cv && in_flight(ct) && !mdone[ct];
    ret = ordy && head_done();
    @(posedge clk);
    if (cv && !cok) merr = 1'b1;
    if (cok) mdone[ct] = 1'b1;
    if (ret) begin
      mdone[tagq[0]] = 1'b0;
      void'(tagq.pop_front());
    end
    if (acc) begin
      tagq.push_back(next_tag);
      mdone[next_tag]     = 1'b0;
      pend_data[next_tag] = ad;
      expq.push_back(ad);
      next_tag = (next_tag + 1) % DEPTH;
    end
    #1;
  endtask

  task automatic idle();
    bus.alloc_req = 1'b0;
    bus.cmp_vld   = 1'b0;
    bus.cmp_tag   = '0;
    bus.cmp_data  = '0;
    bus.out_rdy   = 1'b0;
  endtask

  task automatic model_reset();
    tagq.delete();
    expq.delete();
    foreach (mdone[i]) mdone[i] = 1'b0;
    next_tag = 0;
    merr     = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_alloc_rdy"}, bus.alloc_rdy, 1'b1);
    chk({pfx, "_alloc_tag"}, bus.alloc_tag, 0);
    chk({pfx, "_out_vld"},   bus.out_vld,   1'b0);
    chk({pfx, "_occupancy"}, bus.occupancy, 0);
    chk({pfx, "_err"},       bus.err,       1'b0);
  endtask

  // Called just after a rising edge; rst rises mid-cycle.
  task automatic reset_mid(input string pfx);
    idle();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_reset_outputs(pfx);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    int t;
    bit cv;
    for (int k = 0; k < 300 && tagq.size() != 0; k++) begin
      t  = pick_incomplete();
      cv = (t >= 0);
      cycle(1'b0, '0, cv, cv ? t : 0, cv ? pend_data[t] : '0, ($urandom % 4) != 0);
    end
    cycle(1'b0, '0, 1'b0, 0, '0, 1'b1);
    chk("drain_occupancy", bus.occupancy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0, t;
    bit cv;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Out-of-order completion, in-order release.
    r0 = n_ret;
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'(i * 'h10), 1'b0, 0, '0, 1'b1);
    ord = '{2, 0, 3, 1};
    for (int k = 0; k < 4; k++) cycle(1'b0, '0, 1'b1, ord[k], pend_data[ord[k]], 1'b1);
    repeat (3) cycle(1'b0, '0, 1'b0, 0, '0, 1'b1);
    chk("ooo_retired", n_ret - r0, 4);
    chk("ooo_occupancy", bus.occupancy, 0);

    // Fill to DEPTH, refused 9th request, slot freed by retire, tag wrap.
    reset_mid("rst2");
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, 32'hF00 + i, 1'b0, 0, '0, 1'b0);
    chk("full_alloc_rdy", bus.alloc_rdy, 1'b0);
    chk("full_occupancy", bus.occupancy, DEPTH);
    cycle(1'b0, '0, 1'b1, 0, pend_data[0], 1'b0);
    cycle(1'b1, 32'hABC, 1'b0, 0, '0, 1'b1);
    chk("freed_alloc_rdy", bus.alloc_rdy, 1'b1);
    chk("wrap_alloc_tag", bus.alloc_tag, 0);
    cycle(1'b1, 32'hABD, 1'b0, 0, '0, 1'b0);
    drain();

    // Streaming with fixed completion latency of 3.
    r0 = next_tag;
    t  = n_ret;
    for (int i = 0; i < 104; i++) begin
      cv = (i >= 3) && (i < 103);
      cycle(i < 100, 32'(1000 + i), cv, (r0 + i - 3 + DEPTH) % DEPTH,
            pend_data[(r0 + i - 3 + DEPTH) % DEPTH], 1'b1);
      if (i >= 6 && i < 100) chk("stream_occupancy", bus.occupancy, 4);
    end
    chk("stream_retired", n_ret - t, 100);
    drain();

    // Consumer stall with head done.
    cycle(1'b1, 32'h5A5A_0001, 1'b0, 0, '0, 1'b0);
    cycle(1'b0, '0, 1'b1, tagq[0], pend_data[tagq[0]], 1'b0);
    t = n_ret;
    repeat (5) cycle(1'b0, '0, 1'b0, 0, '0, 1'b0);
    chk("stall_no_retire", n_ret - t, 0);
    cycle(1'b0, '0, 1'b0, 0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0, 0, '0, 1'b1);
    chk("stall_one_retire", n_ret - t, 1);

    // Random mixed traffic.
    for (int i = 0; i < 400; i++) begin
      t  = pick_incomplete();
      cv = (t >= 0) && ($urandom % 2 == 0);
      cycle(($urandom % 3) != 0, $urandom, cv, cv ? t : 0, cv ? pend_data[t] : '0,
            ($urandom % 4) != 0);
    end
    drain();

    // Asynchronous reset with three entries outstanding and head done.
    for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, 1'b0, 0, '0, 1'b0);
    cycle(1'b0, '0, 1'b1, tagq[0], pend_data[tagq[0]], 1'b0);
    cycle(1'b0, '0, 1'b0, 0, '0, 1'b0);
    chk("pre_rst_out_vld", bus.out_vld, 1'b1);
    reset_mid("rst_mid");
    chk("post_rst_alloc_tag", bus.alloc_tag, 0);

    // Protocol errors: stale tag, unallocated tag 5, duplicate completion.
    cycle(1'b1, 32'hA0, 1'b0, 0, '0, 1'b0);
    cycle(1'b1, 32'hA1, 1'b0, 0, '0, 1'b0);
    cycle(1'b0, '0, 1'b1, 2, 32'hDEAD, 1'b0);
    chk("err_stale_tag", bus.err, 1'b1);
    cycle(1'b0, '0, 1'b1, 5, 32'hBEEF, 1'b0);
    cycle(1'b0, '0, 1'b1, 0, pend_data[0], 1'b0);
    cycle(1'b0, '0, 1'b1, 0, 32'h5555, 1'b0);
    repeat (2) cycle(1'b0, '0, 1'b0, 0, '0, 1'b0);
    chk("dup_data_kept", bus.out_data, 32'hA0);
    cycle(1'b0, '0, 1'b1, 1, pend_data[1], 1'b1);
    drain();
    chk("err_sticky", bus.err, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
